// File: rtl/alu_sequencer.sv
// Multi-cycle IDLE->DECODE->EXECUTE->WRITEBACK controller for the 8-bit ALU datapath; write strobe 3 cycles after accept (+HOLD stalls).
// INSTR_READY only in IDLE: a producer holding INSTR_VALID while busy waits; HOLD stalls only EXECUTE.
module alu_sequencer #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           INSTRUCTION,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic                  HOLD,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic                  WRITEENABLE,
  output logic [2:0]            ALUSELECT,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic [7:0]            IMMEDIATE,
  output logic                  BUSY,
  output logic                  ILLEGAL,
  output logic [CNT_W-1:0]      INSTR_COUNT
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  state_t                state;
  logic [7:0]            op_code;
  logic [REG_ADDR_W-1:0] dest_fld;
  logic [REG_ADDR_W-1:0] src1_fld;
  logic [REG_ADDR_W-1:0] src2_fld;
  logic                  op_legal;
  logic [2:0]            op_sel;
  logic                  op_imm;
  logic                  op_neg;
  logic                  to_idle;
  logic                  unused_instr;

  assign op_code  = INSTRUCTION[31:24];
  assign dest_fld = INSTRUCTION[16 +: REG_ADDR_W];
  assign src1_fld = INSTRUCTION[8 +: REG_ADDR_W];
  assign src2_fld = INSTRUCTION[0 +: REG_ADDR_W];
  // Upper register-field bits are architecturally ignored.
  assign unused_instr = ^INSTRUCTION;

  // Decoded at acceptance so every control output leaves a flop.
  always_comb begin
    op_legal = 1'b1;
    op_sel   = 3'b000;
    op_imm   = 1'b0;
    op_neg   = 1'b0;
    case (op_code)
      OP_LOADI: op_imm = 1'b1;
      OP_MOV:   op_sel = 3'b000;
      OP_ADD:   op_sel = 3'b001;
      OP_SUB: begin
        op_sel = 3'b001;
        op_neg = 1'b1;
      end
      OP_AND:   op_sel = 3'b010;
      OP_OR:    op_sel = 3'b011;
      default:  op_legal = 1'b0;
    endcase
  end

  assign to_idle = (state == WRITEBACK) || ((state == DECODE) && ILLEGAL);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      INSTR_READY <= 1'b1;
      BUSY        <= 1'b0;
      ILLEGAL     <= 1'b0;
      WRITEENABLE <= 1'b0;
      ALUSELECT   <= 3'b000;
      IMM_SEL     <= 1'b0;
      NEG_SEL     <= 1'b0;
      READREG1    <= '0;
      READREG2    <= '0;
      WRITEREG    <= '0;
      IMMEDIATE   <= 8'h00;
      INSTR_COUNT <= '0;
    end else begin
      ILLEGAL <= 1'b0;
      case (state)
        IDLE: begin
          if (INSTR_VALID) begin
            state       <= DECODE;
            INSTR_READY <= 1'b0;
            BUSY        <= 1'b1;
            // mov routes its single source through ALU DATA1.
            READREG1    <= (op_code == OP_MOV) ? src2_fld : src1_fld;
            READREG2    <= src2_fld;
            WRITEREG    <= dest_fld;
            IMMEDIATE   <= INSTRUCTION[7:0];
            ALUSELECT   <= op_sel;
            IMM_SEL     <= op_imm;
            NEG_SEL     <= op_neg;
            ILLEGAL     <= ~op_legal;
          end
        end
        DECODE: begin
          if (!ILLEGAL) state <= EXECUTE;
        end
        EXECUTE: begin
          if (!HOLD) begin
            state       <= WRITEBACK;
            WRITEENABLE <= 1'b1;
            INSTR_COUNT <= INSTR_COUNT + CNT_W'(1);
          end
        end
        default: ;
      endcase

      if (to_idle) begin
        state       <= IDLE;
        INSTR_READY <= 1'b1;
        BUSY        <= 1'b0;
        WRITEENABLE <= 1'b0;
        ALUSELECT   <= 3'b000;
        IMM_SEL     <= 1'b0;
        NEG_SEL     <= 1'b0;
        READREG1    <= '0;
        READREG2    <= '0;
        WRITEREG    <= '0;
        IMMEDIATE   <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed sequences with literal expectations, then randomized traffic
// checked every cycle against a timing-level model of the instruction lifecycle.
module tb_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = 32'h0;
  logic        INSTR_VALID = 1'b0;
  logic        HOLD = 1'b0;
  logic        INSTR_READY;
  logic [2:0]  READREG1, READREG2, WRITEREG;
  logic        WRITEENABLE;
  logic [2:0]  ALUSELECT;
  logic        IMM_SEL, NEG_SEL;
  logic [7:0]  IMMEDIATE;
  logic        BUSY, ILLEGAL;
  logic [7:0]  INSTR_COUNT;

  alu_sequencer #(.REG_ADDR_W(3), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .HOLD(HOLD), .READREG1(READREG1), .READREG2(READREG2),
    .WRITEREG(WRITEREG), .WRITEENABLE(WRITEENABLE), .ALUSELECT(ALUSELECT), .IMM_SEL(IMM_SEL),
    .NEG_SEL(NEG_SEL), .IMMEDIATE(IMMEDIATE), .BUSY(BUSY), .ILLEGAL(ILLEGAL),
    .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       ill;
    logic       we;
    logic       imm_sel;
    logic       neg_sel;
    logic [2:0] alu;
    logic [2:0] rr1;
    logic [2:0] rr2;
    logic [2:0] wr;
    logic [7:0] imm;
    logic [7:0] cnt;
  } obs_t;

  // Model: an accepted instruction is "age" cycles old; decode at age 1, execute from age 2,
  // each HOLD seen in execute adds a stall, writeback at age 3+stall.
  bit          m_act = 1'b0;
  logic [31:0] m_ins = 32'h0;
  int          m_age = 0;
  int          m_stall = 0;
  int          m_cnt = 0;

  function automatic void alu_ctl(input logic [7:0] op, output bit legal, output logic [2:0] sel,
                                  output logic imm, output logic neg);
    legal = 1'b1; sel = 3'd0; imm = 1'b0; neg = 1'b0;
    case (op)
      8'h00: imm = 1'b1;
      8'h01: sel = 3'd0;
      8'h02: sel = 3'd1;
      8'h03: begin sel = 3'd1; neg = 1'b1; end
      8'h04: sel = 3'd2;
      8'h05: sel = 3'd3;
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    bit legal;
    logic [2:0] sel;
    logic imm, neg;
    logic [7:0] op, d, s1, s2;
    e = '0;
    e.cnt = m_cnt[7:0];
    if (!m_act) begin
      e.rdy = 1'b1;
      return e;
    end
    {op, d, s1, s2} = m_ins;
    alu_ctl(op, legal, sel, imm, neg);
    e.busy = 1'b1;
    e.rr1 = (op == 8'h01) ? s2[2:0] : s1[2:0];
    e.rr2 = s2[2:0];
    e.wr  = d[2:0];
    e.imm = s2;
    if (legal) begin
      e.alu = sel;
      e.imm_sel = imm;
      e.neg_sel = neg;
      e.we = (m_age == 3 + m_stall);
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  initial begin : compare
    obs_t got, want;
    bit legal;
    logic [2:0] sel;
    logic imm, neg;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        m_act = 1'b0;
        m_cnt = 0;
      end
      got = '{rdy: INSTR_READY, busy: BUSY, ill: ILLEGAL, we: WRITEENABLE, imm_sel: IMM_SEL,
              neg_sel: NEG_SEL, alu: ALUSELECT, rr1: READREG1, rr2: READREG2, wr: WRITEREG,
              imm: IMMEDIATE, cnt: INSTR_COUNT};
      want = model_out();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle t=%0t got rdy=%b busy=%b ill=%b we=%b alu=%0d isel=%b nsel=%b rr1=%0d rr2=%0d wr=%0d imm=%h cnt=%0d want rdy=%b busy=%b ill=%b we=%b alu=%0d isel=%b nsel=%b rr1=%0d rr2=%0d wr=%0d imm=%h cnt=%0d",
                 $time, got.rdy, got.busy, got.ill, got.we, got.alu, got.imm_sel, got.neg_sel,
                 got.rr1, got.rr2, got.wr, got.imm, got.cnt, want.rdy, want.busy, want.ill,
                 want.we, want.alu, want.imm_sel, want.neg_sel, want.rr1, want.rr2, want.wr,
                 want.imm, want.cnt);
      end
      if (RESET) begin
        if (!m_act) begin
          if (INSTR_VALID) begin
            m_act = 1'b1; m_ins = INSTRUCTION; m_age = 1; m_stall = 0;
          end
        end else begin
          alu_ctl(m_ins[31:24], legal, sel, imm, neg);
          if (!legal) m_act = 1'b0;
          else if (m_age == 3 + m_stall) m_act = 1'b0;
          else if (m_age == 1) m_age = 2;
          else begin
            if (HOLD) m_stall++;
            else m_cnt = (m_cnt + 1) % 256;
            m_age++;
          end
        end
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents an instruction and returns one step after the edge that accepted it (DECODE cycle).
  task automatic send(input logic [31:0] ins);
    int n;
    n = 0;
    INSTRUCTION = ins;
    INSTR_VALID = 1'b1;
    while (!INSTR_READY && n < 40) begin
      tick();
      n++;
    end
    if (!INSTR_READY) lit("accept_timeout", INSTR_READY, 1);
    tick();
    INSTR_VALID = 1'b0;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [7:0] op;
    op = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5));
    return {op, 24'($urandom)};
  endfunction

  initial begin : drive
    int k, prev, guard;
    bit r, rdy_prev;

    repeat (3) tick();
    lit("rst_ready", INSTR_READY, 1);
    lit("rst_busy", BUSY, 0);
    lit("rst_we", WRITEENABLE, 0);
    lit("rst_count", INSTR_COUNT, 0);
    RESET = 1'b1;
    tick();

    // add r4 = r1 + r2
    send(32'h02_04_01_02);
    lit("add_rr1", READREG1, 1);
    lit("add_rr2", READREG2, 2);
    tick();
    lit("add_alu", ALUSELECT, 1);
    lit("add_neg", NEG_SEL, 0);
    tick();
    lit("add_we", WRITEENABLE, 1);
    lit("add_wr", WRITEREG, 4);
    lit("add_cnt", INSTR_COUNT, 1);
    tick();
    lit("add_idle_we", WRITEENABLE, 0);
    lit("add_idle_rdy", INSTR_READY, 1);

    // loadi r3 = 5, then sub r5 = r3 - r3
    send(32'h00_03_00_05);
    lit("loadi_isel", IMM_SEL, 1);
    lit("loadi_imm", IMMEDIATE, 5);
    lit("loadi_alu", ALUSELECT, 0);
    tick(); tick();
    lit("loadi_we", WRITEENABLE, 1);
    lit("loadi_wr", WRITEREG, 3);
    tick();
    send(32'h03_05_03_03);
    lit("sub_neg", NEG_SEL, 1);
    lit("sub_alu", ALUSELECT, 1);
    tick(); tick();
    lit("sub_wr", WRITEREG, 5);
    lit("sub_cnt", INSTR_COUNT, 3);
    tick();

    // unknown op-code 0x07
    send(32'h07_01_02_03);
    lit("ill_pulse", ILLEGAL, 1);
    lit("ill_we", WRITEENABLE, 0);
    tick();
    lit("ill_clear", ILLEGAL, 0);
    lit("ill_idle", INSTR_READY, 1);
    lit("ill_cnt", INSTR_COUNT, 3);

    // or with three HOLD cycles, next instruction waiting the whole time
    send(32'h05_06_01_02);
    HOLD = 1'b1;
    INSTRUCTION = 32'h02_07_01_01;
    INSTR_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      lit("hold_alu", ALUSELECT, 3);
      lit("hold_we", WRITEENABLE, 0);
      lit("hold_rdy", INSTR_READY, 0);
    end
    HOLD = 1'b0;
    tick();
    lit("hold_wb_we", WRITEENABLE, 1);
    lit("hold_wb_alu", ALUSELECT, 3);
    lit("hold_wb_cnt", INSTR_COUNT, 4);
    tick();
    lit("pend_rdy", INSTR_READY, 1);
    tick();
    INSTR_VALID = 1'b0;
    lit("pend_rr1", READREG1, 1);
    lit("pend_wr", WRITEREG, 7);
    tick(); tick(); tick();

    // mov r2 = r6 (DATA1 sourced from the src2 field)
    send(32'h01_02_05_06);
    lit("mov_rr1", READREG1, 6);
    lit("mov_isel", IMM_SEL, 0);
    tick(); tick();
    lit("mov_wr", WRITEREG, 2);
    lit("mov_cnt", INSTR_COUNT, 6);
    tick();

    // asynchronous reset in the middle of EXECUTE
    send(32'h02_01_02_03);
    HOLD = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    #1;
    lit("arst_we", WRITEENABLE, 0);
    lit("arst_cnt", INSTR_COUNT, 0);
    lit("arst_rdy", INSTR_READY, 1);
    lit("arst_busy", BUSY, 0);
    HOLD = 1'b0;
    tick();
    RESET = 1'b1;
    tick();

    // 256 back-to-back movs: counter wraps, issue every 4 cycles
    INSTRUCTION = {8'h01, 24'($urandom)};
    INSTR_VALID = 1'b1;
    k = 0; prev = 0; guard = 0;
    while (k < 256 && guard < 1200) begin
      r = INSTR_READY;
      tick();
      guard++;
      if (r) begin
        if (k > 0) lit("issue_interval", cyc - prev, 4);
        prev = cyc;
        k++;
        INSTRUCTION = {8'h01, 24'($urandom)};
      end
    end
    INSTR_VALID = 1'b0;
    lit("wrap_accepted", k, 256);
    lit("wrap_pre", INSTR_COUNT, 255);
    tick(); tick();
    lit("wrap_we", WRITEENABLE, 1);
    lit("wrap_cnt", INSTR_COUNT, 0);
    tick();

    // randomized traffic, HOLD, and occasional reset pulses
    rdy_prev = INSTR_READY;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!RESET) RESET = 1'b1;
      else if ($urandom_range(0, 299) == 0) RESET = 1'b0;
      if (INSTR_VALID && rdy_prev) INSTR_VALID = 1'b0;
      if (!INSTR_VALID && $urandom_range(0, 2) != 0) begin
        INSTRUCTION = rand_ins();
        INSTR_VALID = 1'b1;
      end
      HOLD = ($urandom_range(0, 2) == 0);
      rdy_prev = INSTR_READY;
    end
    INSTR_VALID = 1'b0;
    HOLD = 1'b0;
    RESET = 1'b1;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
